sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
Shares one synchronous single-port SRAM between the IF-stage instruction fetch and the EX-stage data access when the core is built against a unified memory. It grants at most one requester per cycle and routes the one-cycle-late read data back to the correct requester. It holds each requester's last returned word stable and raises a stall request to CTRL whenever a requester is denied. A starvation counter guarantees instruction fetch progress under back-to-back data traffic.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_MAX, 4, consecutive data grants allowed while fetch is waiting; the next conflict then goes to fetch (range 1..15)

Ports:
clk  in  1  core clock; all state on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
inst_en  in  1  fetch request this cycle
inst_wen  in  4  fetch byte-write enables (0 for reads)
inst_addr  in  ADDR_W  fetch address
inst_wdata  in  DATA_W  fetch write data
inst_rdata  out  DATA_W  fetch read data, valid the cycle after the grant
data_en  in  1  data request this cycle
data_wen  in  4  data byte-write enables; nonzero = store
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  store data
data_rdata  out  DATA_W  load data, valid the cycle after the grant
mem_en  out  1  shared SRAM enable
mem_wen  out  4  shared SRAM byte-write enables
mem_addr  out  ADDR_W  shared SRAM address
mem_wdata  out  DATA_W  shared SRAM write data
mem_rdata  in  DATA_W  shared SRAM read data, one cycle after mem_en
stallreq_for_arb  out  1  to CTRL: a requester was denied this cycle
gnt_inst  out  1  fetch granted this cycle
gnt_data  out  1  data granted this cycle

Behaviour:
- Grant is combinational in cycle t:
  - gnt_data = data_en & (~inst_en | starve_cnt < STARVE_MAX)
  - gnt_inst = inst_en & ~gnt_data
- mem_en/mem_wen/mem_addr/mem_wdata come from the granted side. With no grant: all zero.
- stallreq_for_arb = inst_en & data_en (exactly one side loses). It is 0 otherwise, and 0 while rst=0.
- starve_cnt (4 bits):
  - Increments, saturating at STARVE_MAX, on a cycle with gnt_data & inst_en.
  - Clears on gnt_inst, or on any cycle with inst_en=0.
- rd_src register:
  - Captures the source of a read grant for cycle t+1: NONE, INST or DATA.
  - A read grant is a grant with the granted wen==0. A write grant records NONE.
- Read return in cycle t+1:
  - rd_src==INST: inst_rdata=mem_rdata, and inst_hold<=mem_rdata.
  - rd_src==DATA: data_rdata=mem_rdata, and data_hold<=mem_rdata.
  - The non-selected output (or both, when rd_src==NONE) drives its hold register, so it is stable across stalls.
- Read latency is exactly 1 cycle after the grant. There is no extra latency when uncontended.
- Requesters hold en/addr/wdata stable while stalled (CTRL freezes the stages). The arbiter does not latch requests.
- Reset (rst=0, any time, including mid-access):
  - rd_src=NONE, starve_cnt=0, inst_hold=0, data_hold=0.
  - All mem_* outputs, gnt_*, stallreq_for_arb and the rdata outputs read 0.
  - An in-flight read return is discarded.
- On the first edge after rst rises, normal arbitration starts. No warm-up cycle.
- Simultaneous events:
  - A data write and a fetch conflict: the write wins, subject to STARVE_MAX.
  - Both sides idle: rd_src=NONE and the holds are unchanged.
- STARVE_MAX=1 gives strict alternation under continuous conflict.

Test Plan:
- Uncontended fetch: inst_en=1, inst_addr=0xBFC00000, data_en=0, mem_rdata=0x3C010001 next cycle -> mem_en=1 and mem_addr=0xBFC00000 in cycle t; inst_rdata=0x3C010001 in t+1; stallreq_for_arb=0 throughout.
- Conflict, load wins: inst_en=1 and data_en=1 (addr 0x80001000, wen=0) in cycle t -> gnt_data=1, stallreq_for_arb=1, mem_addr=0x80001000; in t+1 data_rdata=mem_rdata while inst_rdata keeps the previous fetched word.
- Starvation: both requesting continuously, STARVE_MAX=4 -> grant sequence D,D,D,D,I,D,D,D,D,I; starve_cnt reaches 4 and then clears on the I grant.
- Store: data_en=1, data_wen=0xF, data_wdata=0xDEADBEEF, inst idle -> mem_wen=0xF and mem_wdata=0xDEADBEEF; next cycle data_rdata is unchanged (rd_src=NONE).
- Hold stability: fetch returns 0x12345678; then 3 idle cycles with mem_rdata randomized -> inst_rdata stays 0x12345678.
- Async reset mid-read: rst=0 between the grant and the return edge -> all outputs read 0 immediately; after release the stale mem_rdata is not forwarded and the holds are 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - fetch/data arbiter for one shared single-port SRAM
module sram_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_en,
   input  logic [3:0]        inst_wen,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [DATA_W-1:0] inst_wdata,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_en,
   input  logic [3:0]        data_wen,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              mem_en,
   output logic [3:0]        mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stallreq_for_arb,
   output logic              gnt_inst,
   output logic              gnt_data
);

   localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

   // Owner of the read word that the SRAM returns on the next cycle.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_INST = 2'd1,
      SRC_DATA = 2'd2
   } src_e;

   src_e              r_rd_src;
   src_e              w_rd_src_nxt;
   logic [3:0]        r_starve_cnt;
   logic [3:0]        w_starve_nxt;
   logic [DATA_W-1:0] r_inst_hold;
   logic [DATA_W-1:0] r_data_hold;
   logic              w_gnt_inst;
   logic              w_gnt_data;

   // Data wins unless fetch has already waited through STARVE_MAX data grants; nothing is granted in reset.
   always_comb begin
      w_gnt_data = rst & data_en & (~inst_en | (r_starve_cnt < LP_STARVE_MAX));
      w_gnt_inst = rst & inst_en & ~w_gnt_data;
   end

   // Steer the granted side onto the SRAM bus; idle bus is all zero.
   always_comb begin
      mem_en    = 1'b0;
      mem_wen   = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_gnt_inst) begin
         mem_en    = 1'b1;
         mem_wen   = inst_wen;
         mem_addr  = inst_addr;
         mem_wdata = inst_wdata;
      end else if (w_gnt_data) begin
         mem_en    = 1'b1;
         mem_wen   = data_wen;
         mem_addr  = data_addr;
         mem_wdata = data_wdata;
      end
   end

   assign gnt_inst         = w_gnt_inst;
   assign gnt_data         = w_gnt_data;
   assign stallreq_for_arb = rst & inst_en & data_en;

   // Next read owner and starvation count; writes return nothing, so they record NONE.
   always_comb begin
      w_rd_src_nxt = SRC_NONE;
      if (w_gnt_inst && (inst_wen == 4'd0)) begin
         w_rd_src_nxt = SRC_INST;
      end else if (w_gnt_data && (data_wen == 4'd0)) begin
         w_rd_src_nxt = SRC_DATA;
      end

      w_starve_nxt = r_starve_cnt;
      if (w_gnt_inst || !inst_en) begin
         w_starve_nxt = 4'd0;
      end else if (w_gnt_data) begin
         w_starve_nxt = (r_starve_cnt >= LP_STARVE_MAX) ? LP_STARVE_MAX : r_starve_cnt + 4'd1;
      end
   end

   // State update; the returning word is captured into the owner's hold so it stays stable across stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_src     <= SRC_NONE;
         r_starve_cnt <= 4'd0;
         r_inst_hold  <= '0;
         r_data_hold  <= '0;
      end else begin
         r_rd_src     <= w_rd_src_nxt;
         r_starve_cnt <= w_starve_nxt;
         if (r_rd_src == SRC_INST) begin
            r_inst_hold <= mem_rdata;
         end
         if (r_rd_src == SRC_DATA) begin
            r_data_hold <= mem_rdata;
         end
      end
   end

   assign inst_rdata = (r_rd_src == SRC_INST) ? mem_rdata : r_inst_hold;
   assign data_rdata = (r_rd_src == SRC_DATA) ? mem_rdata : r_data_hold;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

   localparam int SM = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_en = 1'b0;
   logic [3:0]  inst_wen = '0;
   logic [31:0] inst_addr = '0;
   logic [31:0] inst_wdata = '0;
   logic [31:0] inst_rdata;
   logic        data_en = 1'b0;
   logic [3:0]  data_wen = '0;
   logic [31:0] data_addr = '0;
   logic [31:0] data_wdata = '0;
   logic [31:0] data_rdata;
   logic        mem_en;
   logic [3:0]  mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        stallreq_for_arb;
   logic        gnt_inst;
   logic        gnt_data;

   sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst(rst),
      .inst_en(inst_en), .inst_wen(inst_wen), .inst_addr(inst_addr),
      .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
      .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_rdata(data_rdata),
      .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .stallreq_for_arb(stallreq_for_arb), .gnt_inst(gnt_inst), .gnt_data(gnt_data)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model state: who owns next cycle's returned word, last word seen by each side,
   // and how many data grants in a row fetch has sat through.
   int          m_pend;   // 0 nobody, 1 fetch, 2 data
   logic [31:0] m_ih, m_dh;
   int          m_wait;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_ih = '0; m_dh = '0; m_wait = 0;
   endtask

   // Compare every output against what the arbitration rules say for the current inputs.
   task automatic check_model();
      logic        gd, gi;
      logic [31:0] ea, ew;
      logic [3:0]  ewen;
      gd = data_en && (!inst_en || m_wait < SM);
      gi = inst_en && !gd;
      ea = gi ? inst_addr : gd ? data_addr : 32'd0;
      ew = gi ? inst_wdata : gd ? data_wdata : 32'd0;
      ewen = gi ? inst_wen : gd ? data_wen : 4'd0;
      chk("gnt_inst", {31'd0, gnt_inst}, {31'd0, gi});
      chk("gnt_data", {31'd0, gnt_data}, {31'd0, gd});
      chk("stall", {31'd0, stallreq_for_arb}, {31'd0, inst_en & data_en});
      chk("mem_en", {31'd0, mem_en}, {31'd0, gi | gd});
      chk("mem_wen", {28'd0, mem_wen}, {28'd0, ewen});
      chk("mem_addr", mem_addr, ea);
      chk("mem_wdata", mem_wdata, ew);
      chk("inst_rdata", inst_rdata, (m_pend == 1) ? mem_rdata : m_ih);
      chk("data_rdata", data_rdata, (m_pend == 2) ? mem_rdata : m_dh);
   endtask

   // Advance the model across the rising edge using the inputs that were present at it.
   task automatic model_commit();
      logic gd, gi;
      gd = data_en && (!inst_en || m_wait < SM);
      gi = inst_en && !gd;
      if (m_pend == 1) m_ih = mem_rdata;
      if (m_pend == 2) m_dh = mem_rdata;
      m_pend = (gi && inst_wen == 0) ? 1 : (gd && data_wen == 0) ? 2 : 0;
      if (!inst_en || gi) m_wait = 0;
      else if (m_wait < SM) m_wait = m_wait + 1;
   endtask

   // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
   task automatic step();
      #3;
      check_model();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic idle();
      inst_en = 0; inst_wen = 0; inst_addr = 0; inst_wdata = 0;
      data_en = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
   endtask

   task automatic do_reset();
      idle();
      rst = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1;
      model_reset();
   endtask

   typedef struct {
      logic        ien;
      logic [3:0]  iwen;
      logic [31:0] iaddr, iwdata;
      logic        den;
      logic [3:0]  dwen;
      logic [31:0] daddr, dwdata, mrd;
      logic        e_gi, e_gd, e_stall, e_men;
      logic [3:0]  e_mwen;
      logic [31:0] e_maddr, e_mwdata, e_ird, e_drd;
   } vec_t;

   vec_t tbl[7];
   string seq;

   initial begin
      tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[1] = '{1, 0, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'hBFC00000, 0, 0, 0};
      tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h3C010001, 0, 0, 0, 0, 0, 0, 0, 32'h3C010001, 0};
      tbl[3] = '{1, 0, 32'hBFC00004, 0, 1, 0, 32'h80001000, 0, 32'h00000055,
                 0, 1, 1, 1, 0, 32'h80001000, 0, 32'h3C010001, 0};
      tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 0, 32'h3C010001, 32'hCAFEF00D};
      tbl[5] = '{0, 0, 0, 0, 1, 4'hF, 32'h80002000, 32'hDEADBEEF, 32'h00000011,
                 0, 1, 0, 1, 4'hF, 32'h80002000, 32'hDEADBEEF, 32'h3C010001, 32'hCAFEF00D};
      tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h00000022, 0, 0, 0, 0, 0, 0, 0, 32'h3C010001, 32'hCAFEF00D};

      // Outputs held at zero while in reset, even with both sides requesting.
      inst_en = 1; data_en = 1; data_addr = 32'h1234; inst_addr = 32'h5678;
      #2;
      chk("rst_gnt_inst", {31'd0, gnt_inst}, 32'd0);
      chk("rst_gnt_data", {31'd0, gnt_data}, 32'd0);
      chk("rst_stall", {31'd0, stallreq_for_arb}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      do_reset();

      // Directed table: fetch, returned word, contended load, store.
      for (int i = 0; i < 7; i++) begin
         inst_en = tbl[i].ien; inst_wen = tbl[i].iwen; inst_addr = tbl[i].iaddr; inst_wdata = tbl[i].iwdata;
         data_en = tbl[i].den; data_wen = tbl[i].dwen; data_addr = tbl[i].daddr; data_wdata = tbl[i].dwdata;
         mem_rdata = tbl[i].mrd;
         #3;
         chk($sformatf("t%0d_gnt_inst", i), {31'd0, gnt_inst}, {31'd0, tbl[i].e_gi});
         chk($sformatf("t%0d_gnt_data", i), {31'd0, gnt_data}, {31'd0, tbl[i].e_gd});
         chk($sformatf("t%0d_stall", i), {31'd0, stallreq_for_arb}, {31'd0, tbl[i].e_stall});
         chk($sformatf("t%0d_mem_en", i), {31'd0, mem_en}, {31'd0, tbl[i].e_men});
         chk($sformatf("t%0d_mem_wen", i), {28'd0, mem_wen}, {28'd0, tbl[i].e_mwen});
         chk($sformatf("t%0d_mem_addr", i), mem_addr, tbl[i].e_maddr);
         chk($sformatf("t%0d_mem_wdata", i), mem_wdata, tbl[i].e_mwdata);
         chk($sformatf("t%0d_inst_rdata", i), inst_rdata, tbl[i].e_ird);
         chk($sformatf("t%0d_data_rdata", i), data_rdata, tbl[i].e_drd);
         @(posedge clk);
         #1;
      end

      // Continuous conflict: four data grants, then fetch gets through, repeating.
      do_reset();
      inst_en = 1; inst_addr = 32'hBFC00100; data_en = 1; data_addr = 32'h80003000;
      seq = "";
      for (int i = 0; i < 10; i++) begin
         mem_rdata = $urandom;
         #3;
         seq = {seq, gnt_inst ? "I" : gnt_data ? "D" : "-"};
         check_model();
         @(posedge clk);
         model_commit();
         #1;
      end
      n_vec++;
      if (seq != "DDDDIDDDDI") begin
         n_bad++;
         $display("FAIL starve_seq: got %s expected DDDDIDDDDI", seq);
      end

      // Returned fetch word stays put through idle cycles with garbage on the bus.
      do_reset();
      inst_en = 1; inst_addr = 32'hBFC00200;
      step();
      idle();
      mem_rdata = 32'h12345678;
      step();
      for (int i = 0; i < 3; i++) begin
         mem_rdata = $urandom;
         #3;
         chk("hold_inst", inst_rdata, 32'h12345678);
         @(posedge clk);
         model_commit();
         #1;
      end

      // Reset asserted between a load grant and its return.
      do_reset();
      data_en = 1; data_addr = 32'h80004000;
      step();
      idle();
      mem_rdata = 32'hABCDEF01;
      #1 rst = 0;
      #1;
      chk("amid_data_rdata", data_rdata, 32'd0);
      chk("amid_inst_rdata", inst_rdata, 32'd0);
      inst_en = 1; data_en = 1; data_addr = 32'h80004000;
      #1;
      chk("amid_mem_en", {31'd0, mem_en}, 32'd0);
      chk("amid_gnt", {30'd0, gnt_inst, gnt_data}, 32'd0);
      chk("amid_stall", {31'd0, stallreq_for_arb}, 32'd0);
      @(posedge clk);
      #1;
      idle();
      rst = 1;
      model_reset();
      #3;
      chk("arel_data_rdata", data_rdata, 32'd0);
      chk("arel_inst_rdata", inst_rdata, 32'd0);
      @(posedge clk);
      #1;
      #3;
      chk("arel_data_hold", data_rdata, 32'd0);
      @(posedge clk);
      #1;

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         inst_en = ($urandom_range(0, 3) != 0);
         inst_wen = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
         inst_addr = $urandom;
         inst_wdata = $urandom;
         data_en = ($urandom_range(0, 2) != 0);
         data_wen = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'd0;
         data_addr = $urandom;
         data_wdata = $urandom;
         mem_rdata = $urandom;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
